// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default tap masks, checker FSM states and the
// single-step helper used by the generator.
package lfsr_pkg;

  localparam logic [6:0]  TAPS_7  = 7'h60;
  localparam logic [14:0] TAPS_15 = 15'h6000;
  localparam logic [22:0] TAPS_23 = 23'h42_0000;
  localparam logic [30:0] TAPS_31 = 31'h4800_0000;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // One Fibonacci step on a right-aligned state; bits at and above width stay zero.
  function automatic logic [MAX_WIDTH-1:0] lfsr_step(
    input logic [MAX_WIDTH-1:0] state,
    input logic [MAX_WIDTH-1:0] taps,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic                 fb;
    mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    fb   = ^(state & taps);
    return ((state << 1) | {{(MAX_WIDTH-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills its shift register from the stream,
// hunts for a clean run to lock, then counts errors until a window overflows.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 31,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_31),
  parameter int               N         = 1,
  parameter int               LOCK_CNT  = 32,
  parameter int               ERR_LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_data,
  input  logic         clear_err,
  output logic         locked,
  output logic         err_pulse,
  output logic [15:0]  err_count
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(WIDTH);
  localparam logic [RUN_W-1:0]  RUN_DONE  = RUN_W'(LOCK_CNT);
  localparam logic [7:0]        WIN_LIMIT = (ERR_LIMIT > 255) ? 8'd255 : 8'(ERR_LIMIT);

  chk_state_t        state_q, state_d;
  logic [WIDTH-1:0]  cstate_q, cstate_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [5:0]        win_q, win_d;
  logic [7:0]        win_err_q, win_err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              err_pulse_q, err_pulse_d;

  logic [WIDTH-1:0]  cs;
  logic [FILL_W-1:0] fill;
  logic [RUN_W-1:0]  run;
  logic [5:0]        win;
  logic [7:0]        werr;
  logic [3:0]        nerr;
  logic              pred, err, over;
  logic [16:0]       sum;

  always_comb begin
    cs   = cstate_q;
    fill = fill_q;
    run  = run_q;
    win  = win_q;
    werr = win_err_q;
    nerr = '0;
    pred = 1'b0;
    err  = 1'b0;
    over = 1'b0;
    // Oldest bit sits at the top of the word, so walk downwards.
    for (int i = N - 1; i >= 0; i--) begin
      pred = ^(cs & TAPS);
      err  = rx_data[i] ^ pred;
      cs   = {cs[WIDTH-2:0], rx_data[i]};
      if (state_q == HUNT) begin
        if (fill != FILL_DONE)  fill = fill + FILL_W'(1);
        else if (err)           run  = '0;
        else if (run < RUN_DONE) run = run + RUN_W'(1);
      end else begin
        nerr = nerr + {3'b000, err};
        werr = werr + {7'b0000000, err};
        if (werr >= WIN_LIMIT) over = 1'b1;
        win = win + 6'd1;
        if (win == 6'd0) werr = '0;
      end
    end

    state_d     = state_q;
    cstate_d    = cstate_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_d       = win_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = clear_err ? 16'h0000 : err_cnt_q;
    sum         = '0;
    if (rx_valid) begin
      cstate_d = cs;
      if (state_q == HUNT) begin
        fill_d = fill;
        run_d  = run;
        if (run >= RUN_DONE && cs != '0) begin
          state_d   = LOCKED;
          win_d     = '0;
          win_err_d = '0;
        end
      end else begin
        err_pulse_d = (nerr != 4'd0);
        sum         = {1'b0, err_cnt_d} + {13'd0, nerr};
        err_cnt_d   = sum[16] ? 16'hFFFF : sum[15:0];
        if (over) begin
          state_d   = HUNT;
          fill_d    = '0;
          run_d     = '0;
          win_d     = '0;
          win_err_d = '0;
        end else begin
          win_d     = win;
          win_err_d = werr;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= HUNT;
      cstate_q    <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_q       <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cstate_q    <= cstate_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_q       <= win_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule

// File: rtl/lfsr_prbs_engine.sv
// PRBS generator (Fibonacci LFSR, N bits per clock) paired with the
// self-synchronising checker used as the built-in link test.
module lfsr_prbs_engine
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 31,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_31),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               N         = 1,
  parameter int               LOCK_CNT  = 32,
  parameter int               ERR_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [N-1:0]     tx_data,
  input  logic             rx_valid,
  input  logic [N-1:0]     rx_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count
);

  logic [WIDTH-1:0] state_q, state_d;

  // Load has priority over advance; a zero seed would lock up the LFSR.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        state_d = WIDTH'(lfsr_step(MAX_WIDTH'(state_d), MAX_WIDTH'(TAPS), WIDTH));
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign tx_data = state_q[WIDTH-1 -: N];

  prbs_checker #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .N         (N),
    .LOCK_CNT  (LOCK_CNT),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// Directed bench: a 7-bit instance, a default 31-bit loopback instance and a
// byte-wide instance whose error window can never overflow.
module tb_lfsr_prbs_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int totalChecks = 0;
  int badChecks   = 0;

  logic       en7, load7, rxValid7, rxData7, clear7;
  logic [6:0] seed7;
  logic       tx7, locked7, pulse7;
  logic [15:0] count7;

  logic        en31, load31, rxValid31, clear31, rxMode31, flip31;
  logic [30:0] seed31;
  logic        tx31, rxData31, locked31, pulse31;
  logic [15:0] count31;

  logic        en8, load8, rxValid8, clear8, rxMode8;
  logic [30:0] seed8;
  logic [7:0]  tx8, rxData8;
  logic        locked8, pulse8;
  logic [15:0] count8;

  assign rxData31 = rxMode31 ? ~tx31 : (tx31 ^ flip31);
  assign rxData8  = rxMode8 ? ~tx8 : tx8;

  lfsr_prbs_engine #(.WIDTH(7), .TAPS(7'h60), .SEED(7'h01), .N(1)) u7 (
    .clk(clk), .rst_n(reset), .en(en7), .load(load7), .seed_in(seed7), .tx_data(tx7),
    .rx_valid(rxValid7), .rx_data(rxData7), .clear_err(clear7),
    .locked(locked7), .err_pulse(pulse7), .err_count(count7));

  lfsr_prbs_engine u31 (
    .clk(clk), .rst_n(reset), .en(en31), .load(load31), .seed_in(seed31), .tx_data(tx31),
    .rx_valid(rxValid31), .rx_data(rxData31), .clear_err(clear31),
    .locked(locked31), .err_pulse(pulse31), .err_count(count31));

  lfsr_prbs_engine #(.N(8), .ERR_LIMIT(65)) u8 (
    .clk(clk), .rst_n(reset), .en(en8), .load(load8), .seed_in(seed8), .tx_data(tx8),
    .rx_valid(rxValid8), .rx_data(rxData8), .clear_err(clear8),
    .locked(locked8), .err_pulse(pulse8), .err_count(count8));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    assert (observed === expected)
      else begin
        badChecks++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", totalChecks, badChecks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [30:0] model;
  logic [7:0]  expByte;
  logic [6:0]  observedState;
  int          stepCount, firstReturn, lockedBits, pulses, dropAt;
  logic        anyFlag;

  initial begin
    reset = 1'b1;
    en7 = 0; load7 = 0; seed7 = '0; rxValid7 = 0; rxData7 = 0; clear7 = 0;
    en31 = 0; load31 = 0; seed31 = '0; rxValid31 = 0; clear31 = 0; rxMode31 = 0; flip31 = 0;
    en8 = 0; load8 = 0; seed8 = '0; rxValid8 = 0; clear8 = 0; rxMode8 = 0;
    repeat (3) tick();

    checkOutput("rst_tx7", {63'd0, tx7}, 64'd0);
    checkOutput("rst_tx31", {63'd0, tx31}, 64'd0);
    checkOutput("rst_tx8", {56'd0, tx8}, 64'd0);
    checkOutput("rst_locked", {61'd0, locked7, locked31, locked8}, 64'd0);
    checkOutput("rst_pulse", {61'd0, pulse7, pulse31, pulse8}, 64'd0);
    checkOutput("rst_count", {16'd0, count7, count31, count8}, 64'd0);
    reset = 1'b0;

    // 7-bit generator: the seed bit reaches the MSB after six steps
    en7 = 1'b1;
    repeat (5) tick();
    checkOutput("tx7_after5", {63'd0, tx7}, 64'd0);
    tick();
    checkOutput("tx7_after6", {63'd0, tx7}, 64'd1);
    stepCount   = 6;
    firstReturn = 0;
    while (firstReturn == 0 && stepCount < 300) begin
      tick();
      stepCount++;
      observedState = u7.state_q;
      if (observedState == 7'h01) firstReturn = stepCount;
    end
    checkOutput("period7", 64'(firstReturn), 64'd127);

    repeat (3) tick();
    en7 = 1'b0;
    checkOutput("pre_load7", {57'd0, u7.state_q}, 64'h08);
    seed7 = 7'h00; load7 = 1'b1;
    tick();
    checkOutput("load_zero7", {57'd0, u7.state_q}, 64'h01);
    seed7 = 7'h55; en7 = 1'b1;
    tick();
    load7 = 1'b0; en7 = 1'b0;
    checkOutput("load_en_state7", {57'd0, u7.state_q}, 64'h55);
    checkOutput("load_en_tx7", {63'd0, tx7}, 64'd1);

    rxValid7 = 1'b1; rxData7 = 1'b0;
    anyFlag = 1'b0;
    repeat (200) begin
      tick();
      if (locked7) anyFlag = 1'b1;
    end
    checkOutput("zero_never_locks", {63'd0, anyFlag}, 64'd0);
    rxValid7 = 1'b0;

    // Default loopback: 31 fill bits plus 32 clean bits
    en31 = 1'b1; rxValid31 = 1'b1;
    repeat (62) tick();
    checkOutput("lock_after62", {63'd0, locked31}, 64'd0);
    tick();
    checkOutput("lock_after63", {63'd0, locked31}, 64'd1);
    lockedBits = 0;
    anyFlag    = 1'b0;
    repeat (10000) begin
      tick();
      lockedBits++;
      if (count31 != 16'd0 || pulse31 || !locked31) anyFlag = 1'b1;
    end
    checkOutput("clean_run", {63'd0, anyFlag}, 64'd0);

    flip31 = 1'b1;
    tick();
    lockedBits++;
    flip31 = 1'b0;
    pulses = pulse31 ? 1 : 0;
    repeat (40) begin
      tick();
      lockedBits++;
      if (pulse31) pulses++;
    end
    checkOutput("flip_pulses", 64'(pulses), 64'd3);
    checkOutput("flip_count", {48'd0, count31}, 64'd3);
    checkOutput("flip_locked", {63'd0, locked31}, 64'd1);
    clear31 = 1'b1;
    tick();
    lockedBits++;
    clear31 = 1'b0;
    checkOutput("clear_count", {48'd0, count31}, 64'd0);

    // Start the inverted burst on a fresh error window
    repeat (100) begin
      tick();
      lockedBits++;
    end
    while (lockedBits % 64 != 0) begin
      tick();
      lockedBits++;
    end
    rxMode31 = 1'b1;
    dropAt   = 0;
    for (int i = 1; i <= 64 && dropAt == 0; i++) begin
      tick();
      if (!locked31) dropAt = i;
    end
    checkOutput("drop_at", 64'(dropAt), 64'd16);
    repeat (20) tick();
    checkOutput("held_count", {48'd0, count31}, 64'd16);
    checkOutput("held_unlocked", {63'd0, locked31}, 64'd0);
    rxMode31 = 1'b0;
    repeat (62) tick();
    checkOutput("relock_after62", {63'd0, locked31}, 64'd0);
    tick();
    checkOutput("relock_after63", {63'd0, locked31}, 64'd1);
    checkOutput("relock_count", {48'd0, count31}, 64'd16);

    // Byte-wide instance against a bit-serial model, MSB first
    model = 31'd1;
    en8 = 1'b1; rxValid8 = 1'b1;
    for (int w = 0; w < 10; w++) begin
      for (int b = 7; b >= 0; b--) begin
        expByte[b] = model[30];
        model      = {model[29:0], model[30] ^ model[27]};
      end
      checkOutput($sformatf("byte%0d", w), {56'd0, tx8}, {56'd0, expByte});
      tick();
      if (w == 6) checkOutput("lock8_after7", {63'd0, locked8}, 64'd0);
      if (w == 7) checkOutput("lock8_after8", {63'd0, locked8}, 64'd1);
    end
    checkOutput("count8_clean", {48'd0, count8}, 64'd0);
    rxMode8 = 1'b1;
    repeat (8500) tick();
    checkOutput("count8_saturated", {48'd0, count8}, 64'hFFFF);
    checkOutput("locked8_held", {63'd0, locked8}, 64'd1);

    // Asynchronous reset while everything is running
    reset = 1'b1;
    #1;
    checkOutput("midrst_locked", {62'd0, locked31, locked8}, 64'd0);
    checkOutput("midrst_count", {32'd0, count31, count8}, 64'd0);
    checkOutput("midrst_state31", {33'd0, u31.state_q}, 64'd1);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
